// File: rtl/pattern_reader_pkg.sv
// Shared imager constants: frame geometry and reader state encodings.
// The pattern generator imports the same values so writer and reader agree on frame size.
package pattern_reader_pkg;

    localparam int PAT_NUM_ROWS      = 160;
    localparam int PAT_WORDS_PER_ROW = 18;
    localparam int PAT_ROW_GAP       = 4;
    localparam int PAT_WORD_W        = 10;
    localparam int PAT_ROW_W         = 8;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_READ    = 6'b000010,
        S_LATCH   = 6'b000100,
        S_ROWLOAD = 6'b001000,
        S_GAP     = 6'b010000,
        S_DONE    = 6'b100000
    } reader_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pattern_row_counter.sv
// Word, inter-row gap and row counters for the pattern reader, with terminal flags.
module pattern_row_counter
    import pattern_reader_pkg::*;
#(
    parameter int C_NUM_ROWS      = PAT_NUM_ROWS,
    parameter int C_WORDS_PER_ROW = PAT_WORDS_PER_ROW,
    parameter int C_ROW_GAP       = PAT_ROW_GAP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 word_clr,
    input  logic                 word_inc,
    input  logic                 gap_inc,
    input  logic                 row_clr,
    input  logic                 row_inc,
    output logic [PAT_ROW_W-1:0] row_addr,
    output logic                 word_last,
    output logic                 gap_last,
    output logic                 row_last
);

    localparam int WC_W     = $clog2(C_WORDS_PER_ROW + 1);
    localparam int GC_W     = (C_ROW_GAP > 1) ? $clog2(C_ROW_GAP) : 1;
    localparam int GAP_LAST = (C_ROW_GAP > 0) ? C_ROW_GAP - 1 : 0;

    logic [WC_W-1:0] word_cnt;
    logic [GC_W-1:0] gap_cnt;

    // Gap counter self-clears whenever the FSM is not sitting in the gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
            gap_cnt  <= '0;
            row_addr <= '0;
        end else begin
            if (word_clr)
                word_cnt <= '0;
            else if (word_inc)
                word_cnt <= word_cnt + 1'b1;

            if (gap_inc && !gap_last)
                gap_cnt <= gap_cnt + 1'b1;
            else
                gap_cnt <= '0;

            if (row_clr)
                row_addr <= '0;
            else if (row_inc)
                row_addr <= row_addr + 1'b1;
        end
    end

    assign word_last = (word_cnt == WC_W'(C_WORDS_PER_ROW - 1));
    assign gap_last  = (gap_cnt == GC_W'(GAP_LAST));
    assign row_last  = (row_addr == PAT_ROW_W'(C_NUM_ROWS - 1));

endmodule

// File: rtl/pattern_reader.sv
// Streams one subscene of mask words from the pattern FIFO to the imager, row by row,
// with a fixed idle gap after each row load.
module pattern_reader
    import pattern_reader_pkg::*;
#(
    parameter int C_NUM_ROWS      = PAT_NUM_ROWS,
    parameter int C_WORDS_PER_ROW = PAT_WORDS_PER_ROW,
    parameter int C_ROW_GAP       = PAT_ROW_GAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  FIFO_empty,
    input  logic [PAT_WORD_W-1:0] FIFO_dout,
    output logic                  FIFO_rd,
    output logic [PAT_WORD_W-1:0] Pat_data,
    output logic                  Pat_strb,
    output logic [PAT_ROW_W-1:0]  Row_addr,
    output logic                  Row_load,
    output logic                  Subc_done,
    output logic [31:0]           CntSubc,
    output logic [31:0]           Stall_cnt
);

    reader_state_t state, state_nxt;

    logic word_clr, word_inc, gap_inc, row_clr, row_inc, stall_inc;
    logic word_last, gap_last, row_last;

    pattern_row_counter #(
        .C_NUM_ROWS      (C_NUM_ROWS),
        .C_WORDS_PER_ROW (C_WORDS_PER_ROW),
        .C_ROW_GAP       (C_ROW_GAP)
    ) u_row_counter (
        .clk       (clk),
        .rst       (rst),
        .word_clr  (word_clr),
        .word_inc  (word_inc),
        .gap_inc   (gap_inc),
        .row_clr   (row_clr),
        .row_inc   (row_inc),
        .row_addr  (Row_addr),
        .word_last (word_last),
        .gap_last  (gap_last),
        .row_last  (row_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Reads alternate with latch cycles, so FIFO_rd can never fire twice in a row.
    always_comb begin
        state_nxt = state;
        FIFO_rd   = 1'b0;
        word_clr  = 1'b0;
        word_inc  = 1'b0;
        gap_inc   = 1'b0;
        row_clr   = 1'b0;
        row_inc   = 1'b0;
        stall_inc = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    word_clr  = 1'b1;
                    row_clr   = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (FIFO_empty) begin
                    stall_inc = 1'b1;
                end else begin
                    FIFO_rd   = 1'b1;
                    state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                word_inc  = 1'b1;
                state_nxt = word_last ? S_ROWLOAD : S_READ;
            end
            S_ROWLOAD: begin
                word_clr  = 1'b1;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                gap_inc = 1'b1;
                if (gap_last) begin
                    row_inc   = !row_last;
                    state_nxt = row_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                row_clr   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output pulses are registered so Pat_strb lines up with the latched word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Pat_data  <= '0;
            Pat_strb  <= 1'b0;
            Row_load  <= 1'b0;
            Subc_done <= 1'b0;
            CntSubc   <= '0;
            Stall_cnt <= '0;
        end else begin
            Pat_strb  <= (state == S_LATCH);
            Row_load  <= (state == S_ROWLOAD);
            Subc_done <= (state == S_DONE);
            if (state == S_LATCH)
                Pat_data <= FIFO_dout;
            if (state == S_DONE)
                CntSubc <= CntSubc + 32'd1;
            if (stall_inc)
                Stall_cnt <= sat_inc(Stall_cnt);
        end
    end

endmodule

// File: doc/pattern_reader.md
PATTERN_READER -- requirements
Module: pattern_reader

Interface
REQ-001 SHALL have parameter C_NUM_ROWS, default 160, number of pixel rows per subscene.
REQ-002 SHALL have parameter C_WORDS_PER_ROW, default 18, 10-bit words per row.
REQ-003 SHALL have parameter C_ROW_GAP, default 4, idle clk cycles after each Row_load before the next row's first read.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Start  input  1  level; while high at S_IDLE, begin a subscene.
REQ-007 SHALL have port FIFO_empty  input  1  pattern FIFO empty flag.
REQ-008 SHALL have port FIFO_dout  input  10  FIFO read data, valid the cycle after FIFO_rd.
REQ-009 SHALL have port FIFO_rd  output  1  FIFO read strobe.
REQ-010 SHALL have port Pat_data  output  10  word presented to imager mask shift port.
REQ-011 SHALL have port Pat_strb  output  1  one-cycle pulse, Pat_data valid.
REQ-012 SHALL have port Row_addr  output  8  current row index, 0..C_NUM_ROWS-1.
REQ-013 SHALL have port Row_load  output  1  one-cycle pulse after last word of a row.
REQ-014 SHALL have port Subc_done  output  1  one-cycle pulse after last row of a subscene.
REQ-015 SHALL have port CntSubc  output  32  completed-subscene count.
REQ-016 SHALL have port Stall_cnt  output  32  cycles spent waiting on FIFO_empty mid-subscene (saturating).

Function
REQ-017 SHALL implement one-hot states S_IDLE, S_READ, S_LATCH, S_ROWLOAD, S_GAP, S_DONE; any illegal encoding SHALL recover to S_IDLE next cycle.
REQ-018 S_IDLE: Start=1 -> S_READ, word_cnt=0, Row_addr=0.
REQ-019 S_READ: FIFO_rd = ~FIFO_empty (combinational from registered state); if FIFO_empty, stay and increment Stall_cnt; else -> S_LATCH.
REQ-020 S_LATCH: register FIFO_dout into Pat_data, pulse Pat_strb, word_cnt+1; word_cnt reaching C_WORDS_PER_ROW -> S_ROWLOAD, else -> S_READ.
REQ-021 Throughput SHALL be one word per 2 cycles; FIFO_rd never asserted on two consecutive cycles.
REQ-022 S_ROWLOAD: pulse Row_load with Row_addr unchanged, word_cnt=0; -> S_GAP.
REQ-023 S_GAP: count C_ROW_GAP cycles; then if Row_addr == C_NUM_ROWS-1 -> S_DONE, else Row_addr+1 -> S_READ.
REQ-024 S_DONE: pulse Subc_done, CntSubc+1 (wraps at 2^32), Row_addr=0; -> S_IDLE.
REQ-025 Pat_data SHALL hold its last value between strobes; Row_addr SHALL be stable during Pat_strb and Row_load.
REQ-026 Start dropping mid-subscene SHALL NOT abort; the subscene completes.
REQ-027 Start held high SHALL begin the next subscene one cycle after S_DONE (back-to-back).
REQ-028 Stall_cnt SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-029 FIFO_empty toggling in S_LATCH SHALL have no effect; data read the prior cycle is always consumed.
REQ-030 Total FIFO reads per subscene SHALL equal C_NUM_ROWS*C_WORDS_PER_ROW exactly (2880 default).

Reset
REQ-031 rst=0 SHALL asynchronously force S_IDLE, FIFO_rd=0, Pat_data=0, Pat_strb=0, Row_addr=0, Row_load=0, Subc_done=0, CntSubc=0, Stall_cnt=0, internal counters 0.
REQ-032 Reset mid-subscene SHALL discard partial row; no Row_load or Subc_done issued for it.
REQ-033 Deassertion SHALL be synchronised externally; block SHALL require no cycles beyond first clk edge after release.

Structure
REQ-034 State encodings, C_NUM_ROWS and C_WORDS_PER_ROW SHALL live in the shared imager constants package used by the pattern generator, so writer and reader agree on frame size.
REQ-035 A sub-module pattern_row_counter (word_cnt, gap count, Row_addr with terminal flags) is natural; the FSM stays in pattern_reader.

Verification
REQ-036 FIFO preloaded with 2880 words 0..2879 mod 1024, Start pulsed -> 2880 Pat_strb in order, 160 Row_load, Row_addr 0..159, one Subc_done, CntSubc=1, Stall_cnt=0.
REQ-037 FIFO_empty forced high for 50 cycles after word 100 -> Pat_data sequence unbroken, no FIFO_rd while empty, Stall_cnt=50.
REQ-038 Start held high, 5760 words supplied -> two subscenes back-to-back, Subc_done twice, CntSubc=2, Row_addr returns to 0.
REQ-039 rst low during row 37 word 9 -> all outputs 0 asynchronously; after release and Start, first Pat_strb carries next FIFO word, Row_addr=0.
REQ-040 Start deasserted at row 80 -> subscene still completes with 160 Row_load and one Subc_done; block then idles with FIFO_rd=0.
